// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Purpose  : 8N1 UART receiver. Synchronises the serial line, qualifies the
//            start bit at mid-bit, samples 8 data bits (LSB first) and the
//            stop bit at bit centres, and presents each good byte in a
//            one-deep holding register with a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   uartRx     in   1  asynchronous serial line, idle high
//   data       out  8  received byte, valid while dataValid=1
//   dataValid  out  1  holding register holds an unconsumed byte
//   dataReady  in   1  consumer takes the byte when dataValid & dataReady
//   frameError out  1  one-cycle pulse: stop bit sampled low
//   overrun    out  1  one-cycle pulse: good byte overwrote unconsumed byte
//   busy       out  1  receiver FSM is not idle
// ============================================================================
module uart_receiver #(
  parameter int CLKFREQ      = 100_000_000,
  parameter int BAUDRATE     = 9600,
  parameter int CLKS_PER_BIT = CLKFREQ / BAUDRATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uartRx,
  output logic [7:0] data,
  output logic       dataValid,
  input  logic       dataReady,
  output logic       frameError,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t           state_q,     state_d;
  logic             rx_meta_q,   rx_meta_d;
  logic             rx_s_q,      rx_s_d;
  logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       data_q,      data_d;
  logic             valid_q,     valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q,   overrun_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      // Synchroniser resets to the idle line level so reset release
      // never looks like a start bit.
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    rx_meta_d   = uartRx;
    rx_s_d      = rx_meta_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // Consumer handshake; a byte completing this same cycle overrides below,
    // which gives "consume old, load new, stay valid, no overrun".
    if (valid_q && dataReady) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d   = START;
          bit_cnt_d = '0;
        end
      end

      START: begin
        if (bit_cnt_q == HALF_LAST) begin
          bit_cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            // Line went high again before mid-bit: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (rx_s_q) begin
            data_d    = shift_q;
            valid_d   = 1'b1;
            overrun_d = valid_q && !dataReady;
            state_d   = IDLE;
          end else begin
            // Bad frame: held byte is left alone; wait out any break.
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data       = data_q;
  assign dataValid  = valid_q;
  assign frameError = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receiver
// Purpose  : Self-checking bench for uart_receiver (CPB = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

  localparam int CPB      = 16;
  localparam int LOAD_LAT = 2 + CPB / 2 + 9 * CPB;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       uartRx    = 1'b1;
  logic       ready_man = 1'b0;
  logic       rnd_ready = 1'b0;
  logic       rand_ready = 1'b0;
  logic       dataReady;
  logic [7:0] data;
  logic       dataValid;
  logic       frameError;
  logic       overrun;
  logic       busy;

  assign dataReady = rand_ready ? rnd_ready : ready_man;

  always #5 clk = ~clk;

  uart_receiver #(
    .CLKFREQ  (CPB * 9600),
    .BAUDRATE (9600)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uartRx     (uartRx),
    .data       (data),
    .dataValid  (dataValid),
    .dataReady  (dataReady),
    .frameError (frameError),
    .overrun    (overrun),
    .busy       (busy)
  );

  // Edge index: after posedge k, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_ready <= 1'($urandom_range(0, 1));

  // Observation of DUT events, sampled on the falling edge.
  int         load_cnt  = 0;
  int         last_load = -1;
  int         busy_fall = -1;
  int         fe_cnt    = 0;
  int         ov_cnt    = 0;
  int         both_cnt  = 0;
  logic       prev_valid = 1'b0;
  logic       prev_busy  = 1'b0;
  logic       sb_on      = 1'b0;
  logic [7:0] obs_q[$];

  always @(negedge clk) begin
    if ((dataValid && !prev_valid) || overrun) begin
      load_cnt++;
      last_load = cyc;
    end
    if (prev_busy && !busy) busy_fall = cyc;
    if (frameError) fe_cnt++;
    if (overrun) ov_cnt++;
    if (frameError && overrun) both_cnt++;
    if (sb_on && dataValid && dataReady) obs_q.push_back(data);
    prev_valid = dataValid;
    prev_busy  = busy;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first, then nstop bit periods at stop_lvl.
  // The line is left at stop_lvl. e0 is the first edge that sees the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl,
                            input int nstop, output int e0);
    @(posedge clk);
    #1;
    uartRx = 1'b0;
    e0 = cyc + 1;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      uartRx = b[i];
      hold(CPB);
    end
    uartRx = stop_lvl;
    hold(CPB * nstop);
  endtask

  typedef struct {
    logic [7:0] tx;
    bit         stop_ok;
    int         nstop;
    int         brk;
    bit         consume;
    int         exp_load;
    bit         exp_valid;
    logic [7:0] exp_data;
    int         exp_fe;
    int         exp_ov;
  } vec_t;

  vec_t vecs[7];

  task automatic check_good(input string tag, input int e0, input logic [7:0] b);
    chk({tag, "_load_edge"}, last_load, e0 + LOAD_LAT);
    chk({tag, "_busy_fall"}, busy_fall, e0 + LOAD_LAT);
    chk({tag, "_valid"}, int'(dataValid), 1);
    chk({tag, "_data"}, int'(data), int'(b));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, l0, f0, o0, nbad;
    logic [7:0] exp_q[$];
    logic [7:0] b;

    //            tx     ok  ns brk cons load val  data   fe ov
    vecs[0] = '{8'hA5, 1, 2, 0,  1,   1,  1, 8'hA5, 0, 0};
    vecs[1] = '{8'h11, 1, 1, 0,  0,   1,  1, 8'h11, 0, 0};
    vecs[2] = '{8'h22, 1, 1, 0,  1,   1,  1, 8'h22, 0, 1};
    vecs[3] = '{8'h55, 0, 1, 40, 0,   0,  0, 8'h22, 1, 0};
    vecs[4] = '{8'h12, 1, 2, 0,  0,   1,  1, 8'h12, 0, 0};
    vecs[5] = '{8'h44, 0, 1, 0,  1,   0,  1, 8'h12, 1, 0};
    vecs[6] = '{8'h9C, 1, 1, 0,  1,   1,  1, 8'h9C, 0, 0};

    // Reset state.
    hold(3);
    chk("reset_data", int'(data), 0);
    chk("reset_valid", int'(dataValid), 0);
    chk("reset_fe", int'(frameError), 0);
    chk("reset_ov", int'(overrun), 0);
    chk("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    hold(CPB);

    // Table-driven frames.
    foreach (vecs[k]) begin
      l0 = load_cnt; f0 = fe_cnt; o0 = ov_cnt;
      ready_man = 1'b0;
      send_frame(vecs[k].tx, vecs[k].stop_ok, vecs[k].nstop, e0);
      if (!vecs[k].stop_ok) begin
        hold(vecs[k].brk);
        chk($sformatf("v%0d_wait_idle_busy", k), int'(busy), 1);
        uartRx = 1'b1;
        hold(6);
        chk($sformatf("v%0d_wait_idle_exit", k), int'(busy), 0);
      end
      chk($sformatf("v%0d_loads", k), load_cnt - l0, vecs[k].exp_load);
      if (vecs[k].exp_load != 0) begin
        chk($sformatf("v%0d_load_edge", k), last_load, e0 + LOAD_LAT);
        chk($sformatf("v%0d_busy_fall", k), busy_fall, e0 + LOAD_LAT);
      end
      chk($sformatf("v%0d_valid", k), int'(dataValid), int'(vecs[k].exp_valid));
      chk($sformatf("v%0d_data", k), int'(data), int'(vecs[k].exp_data));
      chk($sformatf("v%0d_fe_pulses", k), fe_cnt - f0, vecs[k].exp_fe);
      chk($sformatf("v%0d_ov_pulses", k), ov_cnt - o0, vecs[k].exp_ov);
      if (vecs[k].consume) begin
        ready_man = 1'b1;
        hold(1);
        ready_man = 1'b0;
        chk($sformatf("v%0d_consume", k), int'(dataValid), 0);
      end
      hold(CPB);
    end

    // Glitch: 4 low clocks is shorter than the half-bit qualification.
    l0 = load_cnt; f0 = fe_cnt; o0 = ov_cnt;
    @(posedge clk);
    #1;
    uartRx = 1'b0;
    hold(4);
    uartRx = 1'b1;
    hold(1);
    chk("glitch_busy_start", int'(busy), 1);
    hold(20);
    chk("glitch_busy_end", int'(busy), 0);
    chk("glitch_loads", load_cnt - l0, 0);
    chk("glitch_fe", fe_cnt - f0, 0);
    chk("glitch_ov", ov_cnt - o0, 0);
    chk("glitch_valid", int'(dataValid), 0);

    // Reset in the middle of data bit 4 of 0x77.
    l0 = load_cnt;
    b = 8'h77;
    @(posedge clk);
    #1;
    uartRx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 4; i++) begin
      uartRx = b[i];
      hold(CPB);
    end
    uartRx = b[4];
    hold(CPB / 2);
    chk("midrst_busy_before", int'(busy), 1);
    rst_n  = 1'b0;
    uartRx = 1'b1;
    hold(2);
    chk("midrst_data", int'(data), 0);
    chk("midrst_valid", int'(dataValid), 0);
    chk("midrst_fe", int'(frameError), 0);
    chk("midrst_ov", int'(overrun), 0);
    chk("midrst_busy", int'(busy), 0);
    rst_n = 1'b1;
    hold(3 * CPB);
    chk("midrst_no_delivery", load_cnt - l0, 0);
    send_frame(8'h9E, 1'b1, 1, e0);
    check_good("after_rst", e0, 8'h9E);
    ready_man = 1'b1;
    hold(1);
    ready_man = 1'b0;
    hold(CPB);

    // Back-to-back frames with the consumer always ready.
    o0 = ov_cnt;
    obs_q.delete();
    exp_q = '{8'h00, 8'hFF, 8'h3C};
    sb_on = 1'b1;
    ready_man = 1'b1;
    foreach (exp_q[k]) send_frame(exp_q[k], 1'b1, 1, e0);
    hold(CPB);
    sb_on = 1'b0;
    ready_man = 1'b0;
    chk("b2b_count", obs_q.size(), exp_q.size());
    foreach (exp_q[k]) begin
      if (k < obs_q.size()) chk($sformatf("b2b_byte%0d", k), int'(obs_q[k]), int'(exp_q[k]));
    end
    chk("b2b_ov", ov_cnt - o0, 0);

    // Randomised frames: reference model is the queue of bytes whose stop
    // bit was high; every such byte must reach the consumer in order, every
    // low stop bit must yield exactly one frameError pulse.
    obs_q.delete();
    exp_q.delete();
    f0 = fe_cnt; o0 = ov_cnt;
    nbad = 0;
    sb_on = 1'b1;
    rand_ready = 1'b1;
    for (int f = 0; f < 24; f++) begin
      logic ok;
      int   ns;
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 5) != 0);
      ns = $urandom_range(1, 2);
      send_frame(b, ok, ns, e0);
      uartRx = 1'b1;
      if (ok) exp_q.push_back(b);
      else nbad++;
      hold(CPB + $urandom_range(0, 20));
    end
    rand_ready = 1'b0;
    ready_man  = 1'b1;
    hold(CPB);
    sb_on = 1'b0;
    ready_man = 1'b0;
    chk("rand_count", obs_q.size(), exp_q.size());
    foreach (exp_q[k]) begin
      if (k < obs_q.size()) chk($sformatf("rand_byte%0d", k), int'(obs_q[k]), int'(exp_q[k]));
    end
    chk("rand_fe", fe_cnt - f0, nbad);
    chk("rand_ov", ov_cnt - o0, 0);

    chk("fe_ov_exclusive", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
